// File: rtl/uart_rx_control_module.sv
// UART receive byte assembler: start-edge triggered, mid-bit sampling, 8N1 framing.
// Optional even-parity bit between bit 7 and stop when UART_RX_PARITY_EN is defined.
module uart_rx_control_module #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Pin_In,
  input  logic       H2L_Sig,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       Frame_Err_Sig
`ifdef UART_RX_PARITY_EN
  ,
  output logic       Parity_Err_Sig
`endif
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    if (state_q != StIdle && state_q != StDone && !RX_En_Sig) begin
      // Receive disabled mid-frame: drop the partial byte silently.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (H2L_Sig && RX_En_Sig) begin
            state_d = StStart;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_d = '0;
            if (RX_Pin_In) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              bit_idx_d = '0;
            end
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            shift_d = {RX_Pin_In, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            par_d   = RX_Pin_In;
            state_d = StStop;
          end
        end
`endif
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_d = '0;
            if (RX_Pin_In) begin
              state_d = StDone;
            end else begin
              ferr_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StDone: begin
          cnt_d     = '0;
          rx_data_d = shift_q;
          done_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero.
          perr_d    = ^{shift_q, par_q};
`endif
          state_d   = StIdle;
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  assign RX_Data       = rx_data_q;
  assign RX_Done_Sig   = done_q;
  assign Frame_Err_Sig = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Err_Sig = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_control_module.sv
// Directed bench for uart_rx_control_module at CLKS_PER_BIT=16; honours UART_RX_PARITY_EN.
module tb_uart_rx_control_module;

  localparam int Cpb = 16;
  localparam int Half = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
  localparam int Lat = Half + 10 * Cpb + 1;
`else
  localparam int FrameBits = 10;
  localparam int Lat = Half + 9 * Cpb + 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rx = 1'b1;
  logic       rx_prev = 1'b1;
  logic       H2L_Sig;
  logic       RX_En_Sig = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       Frame_Err_Sig;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Err_Sig;
  logic       last_perr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_lat = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] done_data[$];
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;

  uart_rx_control_module #(
    .CLKS_PER_BIT(Cpb),
    .HALF_BIT    (Half)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_Pin_In    (rx),
    .H2L_Sig      (H2L_Sig),
    .RX_En_Sig    (RX_En_Sig),
    .RX_Data      (RX_Data),
    .RX_Done_Sig  (RX_Done_Sig),
    .Frame_Err_Sig(Frame_Err_Sig)
`ifdef UART_RX_PARITY_EN
    ,
    .Parity_Err_Sig(Parity_Err_Sig)
`endif
  );

  always #5 CLK = ~CLK;

  // Falling-edge detector feeding the receiver, as upstream hardware would.
  always @(posedge CLK) rx_prev <= rx;
  assign H2L_Sig = rx_prev & ~rx;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RX_Done_Sig) begin
      done_cnt++;
      done_data.push_back(RX_Data);
      last_lat = cyc - start_cyc - 1;
      check("done_width", {31'd0, prev_done}, 32'd0);
      check("done_ferr_excl", {31'd0, Frame_Err_Sig}, 32'd0);
`ifdef UART_RX_PARITY_EN
      last_perr = Parity_Err_Sig;
`endif
    end
    if (Frame_Err_Sig) begin
      ferr_cnt++;
      check("ferr_width", {31'd0, prev_ferr}, 32'd0);
    end
`ifdef UART_RX_PARITY_EN
    if (Parity_Err_Sig) check("perr_with_done", {31'd0, RX_Done_Sig}, 32'd1);
`endif
    prev_done = RX_Done_Sig;
    prev_ferr = Frame_Err_Sig;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [FrameBits-1:0] mk(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {stop, d, 1'b0};
`endif
  endfunction

  // Drives the first n bits of a frame, one bit time each, start bit first.
  task automatic send_n(input logic [FrameBits-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      if (i == 0) start_cyc = cyc;
      step(Cpb);
    end
  endtask

  task automatic send(input logic [FrameBits-1:0] f);
    send_n(f, FrameBits);
  endtask

  initial begin
    step(3);
    check("rst_data", {24'd0, RX_Data}, 32'h00);
    check("rst_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("rst_ferr", {31'd0, Frame_Err_Sig}, 32'd0);
    RST = 1'b0;
    step(5);

    send(mk(8'hA5, 1'b1));
    step(4);
    check("a5_cnt", done_cnt, 1);
    check("a5_data", {24'd0, done_data[0]}, 32'hA5);
    check("a5_lat", last_lat, Lat);
    check("a5_ferr", ferr_cnt, 0);

    send(mk(8'h00, 1'b1));
    send(mk(8'hFF, 1'b1));
    step(4);
    check("b2b_cnt", done_cnt, 3);
    check("b2b_data0", {24'd0, done_data[1]}, 32'h00);
    check("b2b_data1", {24'd0, done_data[2]}, 32'hFF);
    check("b2b_lat", last_lat, Lat);

    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(10);
    check("glitch_cnt", done_cnt, 3);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_data", {24'd0, RX_Data}, 32'hFF);
    send(mk(8'hC3, 1'b1));
    step(4);
    check("post_glitch_cnt", done_cnt, 4);
    check("post_glitch_data", {24'd0, done_data[3]}, 32'hC3);

    send(mk(8'h3C, 1'b0));
    rx = 1'b1;
    step(20);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_done_cnt", done_cnt, 4);
    check("ferr_data", {24'd0, RX_Data}, 32'hC3);
    send(mk(8'h11, 1'b1));
    step(4);
    check("after_ferr_cnt", done_cnt, 5);
    check("after_ferr_data", {24'd0, done_data[4]}, 32'h11);

    // Reset pulse in the middle of data bit 4.
    send_n(mk(8'h5A, 1'b1), 5);
    rx = 1'b1;
    step(8);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    check("midrst_data", {24'd0, RX_Data}, 32'h00);
    check("midrst_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("midrst_ferr", {31'd0, Frame_Err_Sig}, 32'd0);
    step(30);
    check("midrst_cnt", done_cnt, 5);
    send(mk(8'h5A, 1'b1));
    step(4);
    check("post_rst_cnt", done_cnt, 6);
    check("post_rst_data", {24'd0, done_data[5]}, 32'h5A);

    send_n(mk(8'h96, 1'b1), 4);
    RX_En_Sig = 1'b0;
    step(4);
    rx = 1'b1;
    step(200);
    RX_En_Sig = 1'b1;
    check("en_drop_cnt", done_cnt, 6);
    check("en_drop_ferr", ferr_cnt, 1);
    check("en_drop_data", {24'd0, RX_Data}, 32'h5A);
    send(mk(8'h96, 1'b1));
    step(4);
    check("post_en_cnt", done_cnt, 7);
    check("post_en_data", {24'd0, done_data[6]}, 32'h96);

`ifdef UART_RX_PARITY_EN
    send(11'b1_1_00000111_0);
    step(4);
    check("par_ok_cnt", done_cnt, 8);
    check("par_ok_data", {24'd0, done_data[7]}, 32'h07);
    check("par_ok_perr", {31'd0, last_perr}, 32'd0);
    send(11'b1_0_00000111_0);
    step(4);
    check("par_bad_cnt", done_cnt, 9);
    check("par_bad_data", {24'd0, done_data[8]}, 32'h07);
    check("par_bad_perr", {31'd0, last_perr}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
